// File: rtl/fas_stream_checker.sv
// Tolerance checker for multi-lane result streams: buffers DUT beats in a small FIFO
// and compares each beat lane-by-lane against a golden stream within +/-TOL.
module fas_stream_checker #(
    parameter int LANES      = 16,
    parameter int DW         = 16,
    parameter int CPLX       = 1,
    parameter int TOL        = 3,
    parameter int DEPTH      = 4,
    parameter int N_BEATS    = 64,
    parameter int FAIL_LIMIT = 48,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            dut_valid,
    output logic                            dut_ready,
    input  logic [LANES*(1+CPLX)*DW-1:0]    dut_data,
    input  logic                            gold_valid,
    output logic                            gold_ready,
    input  logic [LANES*(1+CPLX)*DW-1:0]    gold_data,
    output logic                            err_valid,
    output logic [LANES-1:0]                err_mask,
    output logic [CNT_W-1:0]                err_beat,
    output logic [CNT_W-1:0]                fail_cnt,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [1:0]                      dbg_state,
    output logic [CNT_W-1:0]                dbg_beat_cnt
);

    localparam int NC = 1 + CPLX;
    localparam int LW = NC * DW;
    localparam int W  = LANES * LW;
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [DW:0] TOL_S = (DW + 1)'(TOL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [W-1:0]         mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 start_ok;
    logic                 term;
    logic [W-1:0]         head;
    logic [LANES-1:0]     cmp_mask;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W:0]       fail_sum;
    logic [CNT_W-1:0]     fail_next;

    // A component fails when the exact (DW+1)-bit difference leaves [-TOL, TOL].
    function automatic logic comp_fail(input logic [DW-1:0] d, input logic [DW-1:0] g);
        logic signed [DW:0] diff;
        diff = $signed({d[DW-1], d}) - $signed({g[DW-1], g});
        return (diff > TOL_S) || (diff < -TOL_S);
    endfunction

    function automatic logic [CNT_W:0] popcount(input logic [LANES-1:0] m);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + (CNT_W + 1)'(m[i]);
        end
        return n;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];

    assign busy     = (state == S_RUN);
    assign start_ok = start && (state != S_RUN);

    // Termination is decided on the already-updated counters, so hold both sides off
    // in that cycle: no beat beyond the terminating one is consumed or counted.
    assign term = busy && ((fail_cnt >= CNT_W'(FAIL_LIMIT)) || (beat_cnt == CNT_W'(N_BEATS)));

    // Handshake: a beat moves on any cycle where valid and ready are both high; valid
    // never depends on ready. A DUT beat is pushed into the FIFO, a gold beat pops the
    // FIFO head and is compared against it in the same cycle.
    assign dut_ready  = busy && !fifo_full && !term;
    assign gold_ready = busy && !fifo_empty && !term;
    assign push       = dut_valid && dut_ready;
    assign pop        = gold_valid && gold_ready;

    always_comb begin
        cmp_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (comp_fail(head[k*LW + c*DW +: DW], gold_data[k*LW + c*DW +: DW])) begin
                    cmp_mask[k] = 1'b1;
                end
            end
        end
    end

    assign fail_sum  = {1'b0, fail_cnt} + popcount(cmp_mask);
    assign fail_next = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= dut_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || start_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_valid <= 1'b0;
            err_mask  <= '0;
            err_beat  <= '0;
            fail_cnt  <= '0;
            beat_cnt  <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        fail_cnt <= '0;
                        beat_cnt <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (term) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (fail_cnt == '0) && (beat_cnt == CNT_W'(N_BEATS));
                    end else if (pop) begin
                        err_valid <= |cmp_mask;
                        err_mask  <= cmp_mask;
                        err_beat  <= beat_cnt;
                        fail_cnt  <= fail_next;
                        beat_cnt  <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fas_stream_checker.sv
// Directed bench for fas_stream_checker: per-component tolerance vectors from a table,
// plus hand sequences for back-pressure, abort and mid-run reset.
module tb_fas_stream_checker;

    localparam int LANES   = 16;
    localparam int DW      = 16;
    localparam int CNT_W   = 16;
    localparam int N_BEATS = 64;
    localparam int W       = LANES * 2 * DW;
    localparam int EW      = CNT_W + LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             dut_valid;
    logic             dut_ready;
    logic [W-1:0]     dut_data;
    logic             gold_valid;
    logic             gold_ready;
    logic [W-1:0]     gold_data;
    logic             err_valid;
    logic [LANES-1:0] err_mask;
    logic [CNT_W-1:0] err_beat;
    logic [CNT_W-1:0] fail_cnt;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_beat_cnt;

    always #5 clk = ~clk;

    fas_stream_checker #(
        .LANES(16), .DW(16), .CPLX(1), .TOL(3), .DEPTH(4),
        .N_BEATS(64), .FAIL_LIMIT(48), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_data(dut_data),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_data(gold_data),
        .err_valid(err_valid), .err_mask(err_mask), .err_beat(err_beat),
        .fail_cnt(fail_cnt), .busy(busy), .done(done), .pass(pass),
        .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
    );

    typedef struct {
        int          beat;
        int          lane;
        logic        imag;
        logic [15:0] gold;
        logic [15:0] dutv;
        logic        fail;
    } vec_t;

    int             n_vec = 0;
    int             n_bad = 0;
    logic           mon_en = 1'b0;
    logic [EW-1:0]  exp_q[$];
    logic [W-1:0]   dut_beats [N_BEATS];
    logic [W-1:0]   gold_beats [N_BEATS];
    vec_t           vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every err_valid pulse must match the next expected {beat, mask}.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en && rst && err_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL err_unexpected: got beat %0d mask %h, want no pulse", err_beat, err_mask);
            end else begin
                e = exp_q.pop_front();
                check("err_event", 64'({err_beat, err_mask}), 64'(e));
            end
        end
    end

    task automatic fill_identical();
        logic [31:0] t;
        for (int b = 0; b < N_BEATS; b++) begin
            for (int k = 0; k < LANES; k++) begin
                for (int c = 0; c < 2; c++) begin
                    t = b * 977 + k * 131 + c * 59 + 16'h1234;
                    gold_beats[b][k*32 + c*16 +: 16] = t[15:0];
                    dut_beats[b][k*32 + c*16 +: 16]  = t[15:0];
                end
            end
        end
    endtask

    task automatic set_comp(input int b, input int k, input logic imag,
                            input logic [15:0] g, input logic [15:0] d);
        int off;
        off = k * 32 + (imag ? 0 : 16);
        gold_beats[b][off +: 16] = g;
        dut_beats[b][off +: 16]  = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_stream(input int dut_first, input int gold_lag, input int start_at);
        int  di;
        int  gi;
        int  cyc;
        logic df;
        logic gf;
        di  = dut_first;
        gi  = 0;
        cyc = 0;
        while ((gi < N_BEATS) && !done && (cyc < 1000)) begin
            dut_valid = (di < N_BEATS);
            dut_data  = '0;
            if (di < N_BEATS) dut_data = dut_beats[di];
            gold_valid = (cyc >= gold_lag) && (gi < N_BEATS);
            gold_data  = '0;
            if (gi < N_BEATS) gold_data = gold_beats[gi];
            start = (cyc == start_at);
            @(negedge clk);
            df = dut_valid && dut_ready;
            gf = gold_valid && gold_ready;
            @(posedge clk);
            #1;
            if (df) di++;
            if (gf) gi++;
            cyc++;
        end
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        start      = 1'b0;
        if (cyc >= 1000) begin
            n_vec++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d gold beats, want %0d", gi, N_BEATS);
        end
    endtask

    task automatic end_check(input string name, input logic exp_pass,
                             input int exp_fc, input int exp_bc);
        int n;
        n = 0;
        while (!done && (n < 40)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".done"}, 64'(done), 64'(1));
        check({name, ".pass"}, 64'(pass), 64'(exp_pass));
        check({name, ".fail_cnt"}, 64'(fail_cnt), 64'(exp_fc));
        check({name, ".beat_cnt"}, 64'(dbg_beat_cnt), 64'(exp_bc));
        check({name, ".busy"}, 64'(busy), 64'(0));
        check({name, ".state"}, 64'(dbg_state), 64'(2));
        dut_valid  = 1'b1;
        gold_valid = 1'b1;
        @(negedge clk);
        check({name, ".dut_ready_idle"}, 64'(dut_ready), 64'(0));
        check({name, ".gold_ready_idle"}, 64'(gold_ready), 64'(0));
        @(posedge clk);
        #1;
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        check({name, ".pass_stable"}, 64'(pass), 64'(exp_pass));
        check({name, ".exp_q_left"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".dut_ready"}, 64'(dut_ready), 64'(0));
        check({name, ".gold_ready"}, 64'(gold_ready), 64'(0));
        check({name, ".err_valid"}, 64'(err_valid), 64'(0));
        check({name, ".err_mask"}, 64'(err_mask), 64'(0));
        check({name, ".err_beat"}, 64'(err_beat), 64'(0));
        check({name, ".fail_cnt"}, 64'(fail_cnt), 64'(0));
        check({name, ".busy"}, 64'(busy), 64'(0));
        check({name, ".done"}, 64'(done), 64'(0));
        check({name, ".pass"}, 64'(pass), 64'(0));
        check({name, ".state"}, 64'(dbg_state), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int          pushes;
        int          efc;
        logic [15:0] m;
        int          off;

        // beat, lane, imag, gold, dut, expected fail
        vt[0]  = '{5,  3,  1'b0, 16'h1000, 16'h1003, 1'b0};
        vt[1]  = '{6,  3,  1'b1, 16'h1000, 16'h0FFC, 1'b1};
        vt[2]  = '{8,  0,  1'b0, 16'h7FFF, 16'h8000, 1'b1};
        vt[3]  = '{9,  15, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
        vt[4]  = '{10, 7,  1'b0, 16'h8000, 16'h8003, 1'b0};
        vt[5]  = '{11, 2,  1'b1, 16'h0002, 16'hFFFF, 1'b0};
        vt[6]  = '{12, 2,  1'b1, 16'h0002, 16'hFFFE, 1'b1};
        vt[7]  = '{13, 9,  1'b0, 16'h7FFC, 16'h7FFF, 1'b0};
        vt[8]  = '{14, 9,  1'b0, 16'h7FFB, 16'h7FFF, 1'b1};
        vt[9]  = '{20, 1,  1'b0, 16'h0100, 16'h0200, 1'b1};
        vt[10] = '{20, 4,  1'b1, 16'hFF00, 16'hFF04, 1'b1};
        vt[11] = '{63, 15, 1'b0, 16'h0000, 16'h0004, 1'b1};

        rst        = 1'b0;
        start      = 1'b0;
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        dut_data   = '0;
        gold_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Clean stream, gold two cycles behind, stray start mid-run must be ignored.
        fill_identical();
        pulse_start();
        check("t1.busy", 64'(busy), 64'(1));
        run_stream(0, 2, 30);
        end_check("t1", 1'b1, 0, 64);

        // Tolerance boundaries and wrap cases from the vector table.
        fill_identical();
        for (int i = 0; i < 12; i++) begin
            set_comp(vt[i].beat, vt[i].lane, vt[i].imag, vt[i].gold, vt[i].dutv);
        end
        efc = 0;
        for (int b = 0; b < N_BEATS; b++) begin
            m = '0;
            for (int i = 0; i < 12; i++) begin
                if (vt[i].beat == b && vt[i].fail) m[vt[i].lane] = 1'b1;
            end
            if (m != 16'h0000) begin
                exp_q.push_back({16'(b), m});
                efc += $countones(m);
            end
        end
        pulse_start();
        run_stream(0, 1, -1);
        end_check("t2", 1'b0, efc, 64);

        // Gold stalled: FIFO fills to four beats, then drains in order.
        fill_identical();
        pulse_start();
        pushes     = 0;
        gold_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            dut_valid = 1'b1;
            dut_data  = dut_beats[pushes];
            @(negedge clk);
            check("t4.dut_ready", 64'(dut_ready), 64'(pushes < 4));
            check("t4.gold_ready", 64'(gold_ready), 64'(pushes > 0));
            if (dut_ready) pushes++;
            @(posedge clk);
            #1;
        end
        dut_valid = 1'b0;
        check("t4.pushes", 64'(pushes), 64'(4));
        run_stream(pushes, 0, -1);
        end_check("t4", 1'b1, 0, 64);

        // Three failing lanes per beat: abort once 48 failures are counted.
        fill_identical();
        for (int b = 0; b < N_BEATS; b++) begin
            for (int k = 0; k < LANES; k += 5) begin
                if (k <= 10) begin
                    off = k * 32 + 16;
                    dut_beats[b][off +: 16] = gold_beats[b][off +: 16] + 16'd100;
                end
            end
        end
        for (int b = 0; b < 16; b++) exp_q.push_back({16'(b), 16'h0421});
        pulse_start();
        run_stream(0, 0, -1);
        end_check("t5", 1'b0, 48, 16);

        // Reset with stale beats buffered, then a clean run from scratch.
        pulse_start();
        pushes     = 0;
        gold_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (pushes < 3) begin
                dut_valid = 1'b1;
                dut_data  = '1;
                @(negedge clk);
                if (dut_ready) pushes++;
                @(posedge clk);
                #1;
            end
        end
        dut_valid = 1'b0;
        check("t6.pushes", 64'(pushes), 64'(3));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("t6_reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill_identical();
        pulse_start();
        run_stream(0, 2, -1);
        end_check("t6", 1'b1, 0, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
